// File: rtl/cpu19_pkg.sv
// Shared definitions for the 19-bit CPU interrupt front end.
//   N_IRQ       number of interrupt request lines
//   IRQ_IDX_W   width of an encoded interrupt source index
//   irq_state_t handshake state of the interrupt presenter
package cpu19_pkg;

    localparam int unsigned N_IRQ     = 16;
    localparam int unsigned IRQ_IDX_W = 4;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_PRESENT,
        IRQ_CLEAR
    } irq_state_t;

endpackage

// File: rtl/prio_enc_16to4.sv
// Combinational priority encoder, the inverse of the 4-to-16 select decoder.
//   eff  in   set of candidate sources, bit i = source i
//   enc  out  index of the highest-priority set bit (0 when eff is all zero)
//   any  out  at least one bit of eff is set
// LOW_FIRST=1 gives index 0 the highest priority; LOW_FIRST=0 gives index N-1.
module prio_enc_16to4
    import cpu19_pkg::*;
#(
    parameter int unsigned N         = N_IRQ,
    parameter int unsigned W         = IRQ_IDX_W,
    parameter bit          LOW_FIRST = 1'b1
) (
    input  logic [N-1:0] eff,
    output logic [W-1:0] enc,
    output logic         any
);

    // The last assignment in scan order wins, so scan from the lowest-priority end.
    always_comb begin
        enc = '0;
        any = |eff;
        if (LOW_FIRST) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (eff[i]) enc = W'(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (eff[i]) enc = W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_prio_encoder_16to4.sv
// 16-source interrupt front end: edge-latched pending register, enable mask,
// priority encoder and a valid/ack handshake towards the control unit.
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        level request lines, bit i = source i
//   mask_we    mask write strobe
//   mask_in    new mask value, 1 = source enabled
//   mask_q     current mask
//   pending_q  raw (unmasked) pending register
//   irq_valid  an interrupt ID is presented
//   irq_id     presented source index, frozen while irq_valid=1
//   irq_ack    control unit accepts irq_id
module irq_prio_encoder_16to4
    import cpu19_pkg::*;
#(
    parameter int unsigned N_SRC     = N_IRQ,
    parameter int unsigned IDX_W     = IRQ_IDX_W,
    parameter bit          LOW_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] req,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_in,
    output logic [N_SRC-1:0] mask_q,
    output logic [N_SRC-1:0] pending_q,
    output logic             irq_valid,
    output logic [IDX_W-1:0] irq_id,
    input  logic             irq_ack
);

    logic [N_SRC-1:0] req_d;
    logic             armed_q;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] pending_d;
    logic [N_SRC-1:0] eff;
    logic [IDX_W-1:0] enc;
    logic             any;
    irq_state_t       state_q, state_d;
    logic             valid_d;
    logic [IDX_W-1:0] id_d;

    // req_d resets to zero, so a line already high at reset release would look
    // like an edge. armed_q suppresses detection for that first cycle only.
    assign rise = armed_q ? (req & ~req_d) : '0;

    always_comb begin
        clr = '0;
        if (state_q == IRQ_CLEAR) clr[irq_id] = 1'b1;
    end

    // A new edge on the bit being cleared keeps it pending.
    assign pending_d = (pending_q & ~clr) | rise;
    assign eff       = pending_q & mask_q;

    prio_enc_16to4 #(
        .N         (N_SRC),
        .W         (IDX_W),
        .LOW_FIRST (LOW_FIRST)
    ) u_prio_enc (
        .eff (eff),
        .enc (enc),
        .any (any)
    );

    always_comb begin
        state_d = state_q;
        valid_d = irq_valid;
        id_d    = irq_id;
        unique case (state_q)
            IRQ_IDLE: begin
                if (any) begin
                    id_d    = enc;
                    valid_d = 1'b1;
                    state_d = IRQ_PRESENT;
                end
            end
            IRQ_PRESENT: begin
                if (irq_ack) begin
                    valid_d = 1'b0;
                    state_d = IRQ_CLEAR;
                end
            end
            IRQ_CLEAR: begin
                valid_d = 1'b0;
                state_d = IRQ_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = IRQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d     <= '0;
            armed_q   <= 1'b0;
            pending_q <= '0;
            mask_q    <= '0;
            state_q   <= IRQ_IDLE;
            irq_valid <= 1'b0;
            irq_id    <= '0;
        end else begin
            req_d     <= req;
            armed_q   <= 1'b1;
            pending_q <= pending_d;
            if (mask_we) mask_q <= mask_in;
            state_q   <= state_d;
            irq_valid <= valid_d;
            irq_id    <= id_d;
        end
    end

endmodule

// File: tb/tb_irq_prio_encoder_16to4.sv
module tb_irq_prio_encoder_16to4;

    localparam bit LOW_FIRST = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = '0;
    logic        mask_we = 1'b0;
    logic [15:0] mask_in = '0;
    logic [15:0] mask_q;
    logic [15:0] pending_q;
    logic        irq_valid;
    logic [3:0]  irq_id;
    logic        irq_ack = 1'b0;

    int total = 0;
    int pass  = 0;

    always #5 clk = ~clk;

    irq_prio_encoder_16to4 #(
        .N_SRC     (16),
        .IDX_W     (4),
        .LOW_FIRST (LOW_FIRST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask_we   (mask_we),
        .mask_in   (mask_in),
        .mask_q    (mask_q),
        .pending_q (pending_q),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Behavioural reference: a set of pending sources, a mask, and a presenter
    // that picks the best enabled source, waits for ack, then spends one cycle
    // retiring it before looking again.
    logic [15:0] m_pend, m_mask, m_prev;
    bit          m_seen;       // at least one clock seen since reset
    bit          m_valid, m_retiring;
    int          m_id;

    function automatic int best(input logic [15:0] e);
        int r = -1;
        for (int k = 0; k < 16; k++) begin
            if (e[k] && (r < 0 || !LOW_FIRST)) r = k;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = '0; m_mask = '0; m_prev = '0; m_seen = 0;
            m_valid = 0; m_retiring = 0; m_id = 0;
        end else begin
            logic [15:0] edges, np;
            edges = m_seen ? (req & ~m_prev) : 16'h0;
            np = m_pend | edges;
            if (m_retiring) begin
                np[m_id] = edges[m_id];
                m_retiring = 0;
            end else if (m_valid) begin
                if (irq_ack) begin
                    m_valid = 0;
                    m_retiring = 1;
                end
            end else if ((m_pend & m_mask) != 0) begin
                m_id = best(m_pend & m_mask);
                m_valid = 1;
            end
            m_pend = np;
            m_prev = req;
            m_seen = 1;
            if (mask_we) m_mask = mask_in;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("model valid", {31'b0, irq_valid}, {31'b0, m_valid});
            if (m_valid) chk("model id", {28'b0, irq_id}, m_id);
            chk("model pending", {16'b0, pending_q}, {16'b0, m_pend});
            chk("model mask", {16'b0, mask_q}, {16'b0, m_mask});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [15:0] m);
        mask_we = 1'b1; mask_in = m;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!irq_valid && n < 20) begin
            tick();
            n++;
        end
        chk({nm, " timeout"}, {31'b0, irq_valid}, 32'd1);
    endtask

    task automatic ack_once();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        int exp_seq[4];
        if (LOW_FIRST) exp_seq = '{0, 5, 10, 15};
        else           exp_seq = '{15, 10, 5, 0};

        // 1: reset with all requests high, release without an edge
        req = 16'hFFFF;
        #23;
        chk("rst valid", {31'b0, irq_valid}, 32'd0);
        chk("rst id", {28'b0, irq_id}, 32'd0);
        chk("rst pending", {16'b0, pending_q}, 32'd0);
        chk("rst mask", {16'b0, mask_q}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("post-rst no pending", {16'b0, pending_q}, 32'd0);
        req = '0;
        tick();

        // 2: single source, latency and clear
        write_mask(16'hFFFF);
        req = 16'h0020;
        tick();
        req = '0;
        chk("single pending", {16'b0, pending_q}, 32'h0020);
        chk("single not yet valid", {31'b0, irq_valid}, 32'd0);
        tick();
        chk("single valid", {31'b0, irq_valid}, 32'd1);
        chk("single id", {28'b0, irq_id}, 32'd5);
        ack_once();
        chk("single valid drop", {31'b0, irq_valid}, 32'd0);
        tick();
        chk("single cleared", {16'b0, pending_q}, 32'd0);

        // 3: priority order
        req = 16'h8421;
        tick();
        req = '0;
        for (int k = 0; k < 4; k++) begin
            wait_valid("prio");
            chk($sformatf("prio id %0d", k), {28'b0, irq_id}, exp_seq[k]);
            ack_once();
        end
        tick();
        chk("prio drained", {16'b0, pending_q}, 32'd0);

        // 4: masked source accumulates, delivered after unmask
        write_mask(16'hFFF7);
        req = 16'h0008;
        tick();
        req = '0;
        chk("mask pending", {16'b0, pending_q}, 32'h0008);
        tick(); tick(); tick();
        chk("mask held off", {31'b0, irq_valid}, 32'd0);
        write_mask(16'hFFFF);
        wait_valid("unmask");
        chk("unmask id", {28'b0, irq_id}, 32'd3);
        ack_once();
        tick();

        // 5: edge on the bit being cleared wins
        req = 16'h0004;
        tick();
        req = '0;
        wait_valid("coll");
        chk("coll id", {28'b0, irq_id}, 32'd2);
        ack_once();               // now in the clear cycle
        req = 16'h0004;
        tick();
        req = '0;
        chk("coll kept", {31'b0, pending_q[2]}, 32'd1);
        wait_valid("coll again");
        chk("coll re-id", {28'b0, irq_id}, 32'd2);
        ack_once();
        tick();
        chk("coll drained", {16'b0, pending_q}, 32'd0);

        // 6: frozen ID under new edges and mask writes, then async reset
        req = 16'h0080;
        tick();
        req = '0;
        wait_valid("stab");
        chk("stab id", {28'b0, irq_id}, 32'd7);
        req = 16'h0001;
        write_mask(16'h0000);
        req = '0;
        tick(); tick();
        chk("stab id held", {28'b0, irq_id}, 32'd7);
        chk("stab valid held", {31'b0, irq_valid}, 32'd1);
        chk("stab mask", {16'b0, mask_q}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async valid", {31'b0, irq_valid}, 32'd0);
        chk("async pending", {16'b0, pending_q}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Random traffic against the model
        write_mask(16'hFFFF);
        for (int c = 0; c < 3000; c++) begin
            req     = 16'($urandom & $urandom & $urandom);
            irq_ack = ($urandom_range(0, 2) == 0);
            mask_we = ($urandom_range(0, 15) == 0);
            mask_in = 16'($urandom | $urandom);
            tick();
        end
        irq_ack = 1'b0; mask_we = 1'b0; req = '0;
        tick(); tick();

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
